// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: registered binary grant plus one-hot decode,
// grant held until release, request drop or hold limit.
module rr_onehot_arbiter #(
    parameter int NUM_REQ  = 15,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    output logic               grant_valid_o,
    output logic [3:0]         grant_idx_o,
    output logic [14:0]        grant_onehot_o,
    output logic               timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  idx_q, idx_d;
    logic        to_q, to_d;

    logic [15:0] req_ext;
    logic        found;
    logic [3:0]  pick;
    logic [3:0]  ptr_nxt;
    logic        end_rel, end_drop, end_lim;

    assign req_ext = {{(16-NUM_REQ){1'b0}}, req_i};

    // First set request at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int unsigned j;
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_ext[j[3:0]]) begin
                found = 1'b1;
                pick  = j[3:0];
            end
        end
    end

    assign ptr_nxt  = (idx_q == 4'(NUM_REQ-1)) ? 4'd0 : idx_q + 4'd1;
    assign end_rel  = release_i;
    assign end_drop = !req_ext[idx_q];
    assign end_lim  = (hold_q == 8'(MAX_HOLD-1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    hold_d  = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                if (end_rel || end_drop || end_lim) begin
                    state_d = IDLE;
                    ptr_d   = ptr_nxt;
                    to_d    = end_lim && !end_rel && !end_drop;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            hold_q  <= 8'd0;
            idx_q   <= 4'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
        end
    end

    assign grant_valid_o = (state_q == GRANT);
    assign grant_idx_o   = grant_valid_o ? idx_q : 4'd0;
    assign timeout_o     = to_q;

    always_comb begin
        grant_onehot_o = 15'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot_o[i] = grant_valid_o && (idx_q == 4'(i));
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: fixed vectors, directed corner
// sequences and a random run against a grant-level reference model.
module tb_rr_onehot_arbiter;

    localparam int N = 15;
    localparam int MH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] req;
    logic        rel;
    logic        gv;
    logic [3:0]  gi;
    logic [14:0] goh;
    logic        gto;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the resource and for how long.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_len;
    bit m_to;

    rr_onehot_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .release_i      (rel),
        .grant_valid_o  (gv),
        .grant_idx_o    (gi),
        .grant_onehot_o (goh),
        .timeout_o      (gto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [14:0] q;
        logic        l;
        logic        v;
        logic [3:0]  idx;
        logic [14:0] oh;
        logic        to;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [14:0] q,
                              input logic l);
        bit drop, lim;
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_len = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!m_busy && q[c]) begin
                    m_busy = 1; m_owner = c; m_len = 1;
                end
            end
        end else begin
            drop = !q[m_owner];
            lim  = (m_len == MH);
            if (l || drop || lim) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
                m_to   = lim && !l && !drop;
            end else begin
                m_len++;
                m_to = 0;
            end
        end
    endtask

    // Apply inputs for one cycle, advance the model over the edge.
    task automatic tick(input logic r, input logic [14:0] q,
                        input logic l);
        rst = r; req = q; rel = l;
        @(posedge clk);
        model_edge(r, q, l);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [14:0] eoh;
        eoh = m_busy ? (15'd1 << m_owner) : 15'd0;
        chk({tag, ".valid"}, 32'(gv), 32'(m_busy));
        chk({tag, ".idx"}, 32'(gi), m_busy ? 32'(m_owner) : 32'd0);
        chk({tag, ".onehot"}, 32'(goh), 32'(eoh));
        chk({tag, ".timeout"}, 32'(gto), 32'(m_to));
    endtask

    initial begin
        rst = 1'b1; req = '0; rel = 1'b0;

        // r, req, rel -> valid, idx, onehot, timeout
        vt[0]  = '{1, 15'h0000, 0, 0, 0, 15'h0000, 0};
        vt[1]  = '{1, 15'h0000, 0, 0, 0, 15'h0000, 0};
        vt[2]  = '{0, 15'h0001, 0, 1, 0, 15'h0001, 0};
        vt[3]  = '{0, 15'h0001, 1, 0, 0, 15'h0000, 0};
        vt[4]  = '{0, 15'h0000, 0, 0, 0, 15'h0000, 0};
        vt[5]  = '{1, 15'h4001, 0, 0, 0, 15'h0000, 0};
        vt[6]  = '{0, 15'h4001, 0, 1, 0, 15'h0001, 0};
        vt[7]  = '{0, 15'h4001, 1, 0, 0, 15'h0000, 0};
        vt[8]  = '{0, 15'h4001, 0, 1, 14, 15'h4000, 0};
        vt[9]  = '{0, 15'h4001, 1, 0, 0, 15'h0000, 0};
        vt[10] = '{0, 15'h4001, 0, 1, 0, 15'h0001, 0};
        vt[11] = '{0, 15'h4001, 1, 0, 0, 15'h0000, 0};
        vt[12] = '{0, 15'h4001, 0, 1, 14, 15'h4000, 0};
        vt[13] = '{0, 15'h0008, 0, 0, 0, 15'h0000, 0};
        vt[14] = '{0, 15'h0008, 0, 1, 3, 15'h0008, 0};
        vt[15] = '{0, 15'h7FFF, 0, 1, 3, 15'h0008, 0};
        vt[16] = '{0, 15'h7FF7, 0, 0, 0, 15'h0000, 0};
        vt[17] = '{0, 15'h0080, 0, 1, 7, 15'h0080, 0};
        vt[18] = '{1, 15'h0081, 1, 0, 0, 15'h0000, 0};
        vt[19] = '{0, 15'h0081, 0, 1, 0, 15'h0001, 0};

        for (int i = 0; i < 20; i++) begin
            string nm;
            tick(vt[i].r, vt[i].q, vt[i].l);
            nm = $sformatf("vec%0d", i);
            chk({nm, ".valid"}, 32'(gv), 32'(vt[i].v));
            chk({nm, ".idx"}, 32'(gi), 32'(vt[i].idx));
            chk({nm, ".onehot"}, 32'(goh), 32'(vt[i].oh));
            chk({nm, ".timeout"}, 32'(gto), 32'(vt[i].to));
        end

        // Full round robin with release in every grant cycle.
        tick(1, 15'h0000, 0);
        tick(1, 15'h0000, 0);
        for (int g = 0; g < 16; g++) begin
            tick(0, 15'h7FFF, 0);
            chk("rr.valid", 32'(gv), 32'd1);
            chk("rr.idx", 32'(gi), 32'(g % N));
            chk("rr.popcnt", 32'($countones(goh)), 32'd1);
            tick(0, 15'h7FFF, 1);
            chk("rr.gap", 32'(gv), 32'd0);
        end

        // Hold limit: exactly MH grant cycles, timeout, regrant.
        tick(1, 15'h0000, 0);
        tick(0, 15'h0020, 0);
        chk("to.first", 32'(gi), 32'd5);
        for (int c = 2; c <= MH; c++) begin
            tick(0, 15'h0020, 0);
            chk($sformatf("to.hold%0d", c), 32'(gv), 32'd1);
            chk_model("to.m");
        end
        tick(0, 15'h0020, 0);
        chk("to.idle", 32'(gv), 32'd0);
        chk("to.pulse", 32'(gto), 32'd1);
        tick(0, 15'h0020, 0);
        chk("to.regrant", 32'(gi), 32'd5);
        chk("to.pulse_off", 32'(gto), 32'd0);
        for (int c = 2; c < MH; c++) tick(0, 15'h0020, 0);
        chk("tov.still", 32'(gv), 32'd1);
        tick(0, 15'h0020, 1);
        chk("tov.idle", 32'(gv), 32'd0);
        chk("tov.nopulse", 32'(gto), 32'd0);

        // Random traffic against the model.
        tick(1, 15'h0000, 0);
        chk_model("rnd.rst");
        for (int c = 0; c < 3000; c++) begin
            logic [14:0] q;
            logic        r, l;
            q = 15'($urandom) & 15'($urandom) & 15'($urandom);
            if ($urandom_range(0, 3) == 0) q = 15'($urandom);
            if (m_busy && $urandom_range(0, 9) != 0) q[m_owner] = 1'b1;
            l = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 99) == 0);
            tick(r, q, l);
            chk_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
